// File: rtl/n101_icb_split4.sv
// ICB 1-to-4 address splitter with a default error target for unmapped addresses.
// Responses return in command order; only one target may be outstanding at a time.
`ifndef N101_ADDR_SIZE
`define N101_ADDR_SIZE 32
`endif

module n101_icb_split4 #(
    parameter logic [31:0] REGION_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S0_BASE     = 32'h1000_0000,
    parameter logic [31:0] S1_BASE     = 32'h1000_1000,
    parameter logic [31:0] S2_BASE     = 32'h1000_2000,
    parameter logic [31:0] S3_BASE     = 32'h1000_3000,
    parameter int unsigned OUTS_MAX    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_icb_cmd_valid,
    output logic                       i_icb_cmd_ready,
    input  logic [`N101_ADDR_SIZE-1:0] i_icb_cmd_addr,
    input  logic                       i_icb_cmd_read,
    input  logic [31:0]                i_icb_cmd_wdata,
    output logic                       i_icb_rsp_valid,
    input  logic                       i_icb_rsp_ready,
    output logic [31:0]                i_icb_rsp_rdata,
    output logic                       i_icb_rsp_err,
    output logic [3:0]                 o_icb_cmd_valid,
    input  logic [3:0]                 o_icb_cmd_ready,
    output logic [`N101_ADDR_SIZE-1:0] o_icb_cmd_addr,
    output logic                       o_icb_cmd_read,
    output logic [31:0]                o_icb_cmd_wdata,
    input  logic [3:0]                 o_icb_rsp_valid,
    output logic [3:0]                 o_icb_rsp_ready,
    input  logic [127:0]               o_icb_rsp_rdata,
    input  logic [3:0]                 o_icb_rsp_err
);

    localparam int unsigned AW = `N101_ADDR_SIZE;
    localparam logic [2:0] DFLT = 3'd4;
    localparam logic [3:0] CNT_MAX = 4'(OUTS_MAX);
    localparam logic [AW-1:0] MASK_A = AW'(REGION_MASK);
    localparam logic [AW-1:0] BASE0 = AW'(S0_BASE & REGION_MASK);
    localparam logic [AW-1:0] BASE1 = AW'(S1_BASE & REGION_MASK);
    localparam logic [AW-1:0] BASE2 = AW'(S2_BASE & REGION_MASK);
    localparam logic [AW-1:0] BASE3 = AW'(S3_BASE & REGION_MASK);

    logic [3:0]    cnt;
    logic [2:0]    tgt;
    logic [2:0]    sel;
    logic [AW-1:0] masked;
    logic          stall;
    logic          cmd_hs;
    logic          rsp_hs;
    logic          busy;

    // Lowest matching region wins when regions overlap.
    always_comb begin
        masked = i_icb_cmd_addr & MASK_A;
        if (masked == BASE0) begin
            sel = 3'd0;
        end else if (masked == BASE1) begin
            sel = 3'd1;
        end else if (masked == BASE2) begin
            sel = 3'd2;
        end else if (masked == BASE3) begin
            sel = 3'd3;
        end else begin
            sel = DFLT;
        end
    end

    assign busy  = (cnt != 4'd0);
    assign stall = (cnt == CNT_MAX) || (busy && (sel != tgt));

    // rst_n gates the command side so nothing is offered while reset is held.
    always_comb begin
        o_icb_cmd_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            o_icb_cmd_valid[k] = rst_n & i_icb_cmd_valid & ~stall & (sel == 3'(k));
        end
        if (sel == DFLT) begin
            i_icb_cmd_ready = rst_n & ~stall;
        end else begin
            i_icb_cmd_ready = rst_n & ~stall & o_icb_cmd_ready[sel[1:0]];
        end
    end

    assign o_icb_cmd_addr  = i_icb_cmd_addr;
    assign o_icb_cmd_read  = i_icb_cmd_read;
    assign o_icb_cmd_wdata = i_icb_cmd_wdata;

    always_comb begin
        o_icb_rsp_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            o_icb_rsp_ready[k] = i_icb_rsp_ready & busy & (tgt == 3'(k));
        end
        if (tgt == DFLT) begin
            i_icb_rsp_valid = busy;
            i_icb_rsp_rdata = 32'h0;
            i_icb_rsp_err   = 1'b1;
        end else begin
            i_icb_rsp_valid = busy & o_icb_rsp_valid[tgt[1:0]];
            i_icb_rsp_rdata = o_icb_rsp_rdata[32*tgt[1:0] +: 32];
            i_icb_rsp_err   = o_icb_rsp_err[tgt[1:0]];
        end
    end

    assign cmd_hs = i_icb_cmd_valid & i_icb_cmd_ready;
    assign rsp_hs = i_icb_rsp_valid & i_icb_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
            tgt <= 3'd0;
        end else begin
            if (cmd_hs) begin
                tgt <= sel;
                if (!rsp_hs) begin
                    cnt <= cnt + 4'd1;
                end
            end else if (rsp_hs) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: doc/n101_icb_split4.md
N101_ICB_SPLIT4 -- requirements
Module: n101_icb_split4

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- REGION_MASK, 32'hFFFF_F000, address bits compared for decode
- S0_BASE, 32'h1000_0000, slave 0 region base
- S1_BASE, 32'h1000_1000, slave 1 region base
- S2_BASE, 32'h1000_2000, slave 2 region base
- S3_BASE, 32'h1000_3000, slave 3 region base
- OUTS_MAX, 2, maximum outstanding commands, range 1..15
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_icb_cmd_valid  in  1  master command valid
- i_icb_cmd_ready  out  1  master command accepted
- i_icb_cmd_addr  in  `N101_ADDR_SIZE  command address
- i_icb_cmd_read  in  1  1 = read, 0 = write
- i_icb_cmd_wdata  in  32  write data
- i_icb_rsp_valid  out  1  response valid to master
- i_icb_rsp_ready  in  1  master accepts response
- i_icb_rsp_rdata  out  32  read data
- i_icb_rsp_err  out  1  response error
- o_icb_cmd_valid  out  4  per-slave command valid, one-hot or zero
- o_icb_cmd_ready  in  4  per-slave command ready
- o_icb_cmd_addr  out  `N101_ADDR_SIZE  shared, equals i_icb_cmd_addr
- o_icb_cmd_read  out  1  shared, equals i_icb_cmd_read
- o_icb_cmd_wdata  out  32  shared, equals i_icb_cmd_wdata
- o_icb_rsp_valid  in  4  per-slave response valid
- o_icb_rsp_ready  out  4  per-slave response ready
- o_icb_rsp_rdata  in  128  slave k data at bits [32k+31:32k]
- o_icb_rsp_err  in  4  per-slave response error

Function
REQ-003 Decode SHALL be combinational: sel = lowest k with (addr & REGION_MASK) == (Sk_BASE & REGION_MASK); no match selects internal default target DFLT (index 4).
REQ-004 State SHALL be: outstanding counter cnt (4 bits, 0..OUTS_MAX) and target register tgt (3 bits, 0..4).
REQ-005 stall SHALL be asserted when cnt == OUTS_MAX, or cnt != 0 and sel != tgt; stall uses registered cnt only (no same-cycle response bypass).
REQ-006 o_icb_cmd_valid[k] SHALL equal i_icb_cmd_valid & (sel == k) & ~stall.
REQ-007 i_icb_cmd_ready SHALL equal ~stall & (sel == DFLT ? 1 : o_icb_cmd_ready[sel]).
REQ-008 On command handshake, tgt SHALL load sel; cnt increments unless a response handshake occurs in the same cycle, in which case cnt is unchanged.
REQ-009 On response handshake without command handshake, cnt SHALL decrement; tgt holds.
REQ-010 i_icb_rsp_valid SHALL be cnt != 0 & (tgt == DFLT ? 1 : o_icb_rsp_valid[tgt]); earliest response is the cycle after command acceptance.
REQ-011 When tgt == DFLT, i_icb_rsp_rdata SHALL be 0 and i_icb_rsp_err 1; otherwise both SHALL mux from slave tgt.
REQ-012 o_icb_rsp_ready[k] SHALL equal i_icb_rsp_ready & (cnt != 0) & (tgt == k); responses from non-target slaves are never acknowledged.
REQ-013 Responses SHALL be returned in command order; a write to DFLT completes with err = 1, no slave side effect.
REQ-014 cnt SHALL never exceed OUTS_MAX nor underflow below 0.

Reset
REQ-015 While rst_n is low: cnt = 0, tgt = 0, o_icb_cmd_valid = 0, i_icb_rsp_valid = 0, o_icb_rsp_ready = 0; deassertion is synchronous-safe (first command accepted no earlier than first edge after release).
REQ-016 Reset mid-transaction SHALL discard all outstanding tracking; late slave responses after reset are not forwarded (cnt = 0).

Verification
REQ-017 Read addr 0x1000_2004, slave 2 ready, rsp rdata 0xA5A5_0001 one cycle later -> o_icb_cmd_valid = 4'b0100, master receives 0xA5A5_0001, err 0, cnt returns to 0.
REQ-018 Write addr 0x2000_0000 (unmapped) -> i_icb_cmd_ready = 1 same cycle, next cycle i_icb_rsp_valid = 1, rdata 0, err 1; no o_icb_cmd_valid bit set.
REQ-019 Two back-to-back reads to slave 1 with responses held off, third command -> third stalled (cnt = 2 = OUTS_MAX) until first response handshakes.
REQ-020 Outstanding read to slave 0, new command to slave 3 -> stalled (i_icb_cmd_ready = 0, o_icb_cmd_valid = 0) until cnt = 0, then issued.
REQ-021 Command and response handshake in same cycle with cnt = 1 -> cnt stays 1, tgt updated.
REQ-022 rst_n low with cnt = 2, slave 1 then asserts rsp_valid -> i_icb_rsp_valid = 0, o_icb_rsp_ready = 0, cnt = 0.
